multu_hilo_unit: RTL and testbench

- Sequential 32x32 shift-add multiplier with HI/LO register pair. Sits directly downstream of the ALU control unit and consumes its 6-bit mult control code (SignaltoMut).
- Starts on the multu function code and iterates one bit per clock for 32 clocks.
- Commits the product to HI/LO only on the 6'b111111 HiLo-write code.
- Serves mfhi/mflo reads to the register-file writeback mux.

---
 rtl/multu_hilo_unit_pkg.sv | 17 +
 rtl/multu_hilo_unit_hilo_regs.sv | 46 ++++
 rtl/multu_hilo_unit.sv | 137 +++++++++++++
 tb/tb_multu_hilo_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multu_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: ALU-control function
// codes (also consumed by the ALU control block) and the FSM state encoding.
package multu_hilo_unit_pkg;

  localparam logic [5:0] F_MULTU   = 6'd25;
  localparam logic [5:0] F_MULT    = 6'd24;
  localparam logic [5:0] F_MFHI    = 6'd16;
  localparam logic [5:0] F_MFLO    = 6'd18;
  localparam logic [5:0] F_HILO_WR = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/multu_hilo_unit_hilo_regs.sv
// Architectural HI/LO register pair with a single write enable, plus the
// mfhi/mflo read mux feeding the register-file writeback path.
module multu_hilo_unit_hilo_regs
  import multu_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [5:0]       i_op,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_mfData
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // HI/LO only change on a commit; reads in the commit cycle see the old pair
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_we) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  // Move-from read mux: never stalls, returns zero for any other code
  always_comb begin
    o_mfData = '0;
    case (i_op)
      F_MFHI:  o_mfData = r_hi;
      F_MFLO:  o_mfData = r_lo;
      default: o_mfData = '0;
    endcase
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential shift-add multiplier (one multiplier bit per clock) that holds
// its product until the HiLo-write code commits it to HI/LO.
// Optional build macro MULTU_HILO_SIGNED_EN adds the signed mult opcode
// (magnitude multiply with a final 2W-bit negation when signs differ).
module multu_hilo_unit
  import multu_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             prod_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_prodValid;

  logic               w_start;
  logic               w_commit;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_opA;
  logic [WIDTH-1:0]   w_opB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_accStep;
  logic [2*WIDTH-1:0] w_accFinal;

`ifdef MULTU_HILO_SIGNED_EN
  logic               r_neg;

  assign w_start    = (op == F_MULTU) || (op == F_MULT);
  assign w_opA      = (op == F_MULT && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_opB      = (op == F_MULT && src_b[WIDTH-1]) ? -src_b : src_b;
  assign w_accFinal = r_neg ? -w_accStep : w_accStep;

  // Sign of the result is captured once at start; only signed mult can set it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (r_state == ST_IDLE && w_start) begin
      r_neg <= (op == F_MULT) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    end
  end
`else
  assign w_start    = (op == F_MULTU);
  assign w_opA      = src_a;
  assign w_opB      = src_b;
  assign w_accFinal = w_accStep;
`endif

  assign w_commit   = (r_state == ST_WAIT) && (op == F_HILO_WR);
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  // One shift-add step: the carry out of the add lands in the top bit after the shift
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    w_accStep = {1'b0, r_acc[2*WIDTH-1:1]};
    if (r_acc[0]) begin
      w_accStep = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Control FSM and datapath; held op codes never restart a multiply in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_prodValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_acc   <= {{WIDTH{1'b0}}, w_opB};
            r_mcand <= w_opA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_lastIter) begin
            r_acc       <= w_accFinal;
            r_prodValid <= 1'b1;
            r_state     <= ST_WAIT;
          end else begin
            r_acc <= w_accStep;
          end
        end
        ST_WAIT: begin
          if (w_commit) begin
            r_busy      <= 1'b0;
            r_prodValid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_prodValid <= 1'b0;
        end
      endcase
    end
  end

  multu_hilo_unit_hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hiloRegs (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_we     (w_commit),
    .i_hi     (r_acc[2*WIDTH-1:WIDTH]),
    .i_lo     (r_acc[WIDTH-1:0]),
    .i_op     (op),
    .o_hi     (hi),
    .o_lo     (lo),
    .o_mfData (mf_data)
  );

  assign busy       = r_busy;
  assign prod_valid = r_prodValid;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Scoreboard bench for multu_hilo_unit: stimulus queues time-stamped point
// expectations and expected products; a monitor on the falling edge pops and
// compares them. Honours MULTU_HILO_SIGNED_EN for the signed-mult case.
module tb_multu_hilo_unit;
  import multu_hilo_unit_pkg::*;

  localparam int SEL_BUSY = 0;
  localparam int SEL_PV   = 1;
  localparam int SEL_HI   = 2;
  localparam int SEL_LO   = 3;
  localparam int SEL_MF   = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        prod_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int          cyc;
  int          errors;
  int          checks;
  bit          commitSeen;
  logic [31:0] expHi;
  logic [31:0] expLo;
  chk_t        chkQ[$];
  logic [63:0] prodQ[$];

  multu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .prod_valid (prod_valid),
    .hi         (hi),
    .lo         (lo),
    .mf_data    (mf_data)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp and commit detection use pre-edge DUT values
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && prod_valid === 1'b1 && op == F_HILO_WR) commitSeen = 1'b1;
  end

  // Single comparison point for every check
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares committed products and all expectations due this cycle
  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    if (commitSeen) begin
      commitSeen = 1'b0;
      if (prodQ.size() == 0) begin
        checkOutput("unexpected_commit", {hi, lo}, 64'hx);
      end else begin
        checkOutput("product", {hi, lo}, prodQ.pop_front());
      end
    end
    while (chkQ.size() > 0 && chkQ[0].cyc <= cyc) begin
      c = chkQ.pop_front();
      case (c.sel)
        SEL_BUSY: act = {31'b0, busy};
        SEL_PV:   act = {31'b0, prod_valid};
        SEL_HI:   act = hi;
        SEL_LO:   act = lo;
        default:  act = mf_data;
      endcase
      checkOutput(c.name, {32'b0, act}, {32'b0, c.exp});
    end
  end

  task automatic expectNow(input int sel, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    chkQ.push_back(c);
  endtask

  // Drive inputs for the coming edge, then step to just after it
  task automatic applyStimulus(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    op    = opc;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic readMf(input logic [5:0] opc, input logic [31:0] exp, input string name);
    op = opc;
    expectNow(SEL_MF, exp, name);
    @(posedge clk);
    #1;
  endtask

  // Full multiply with optional one-cycle injected op during RUN, then commit
  task automatic runMultiply(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input int injAt, input logic [5:0] injOp);
    prodQ.push_back(exp);
    applyStimulus(opc, a, b);
    expectNow(SEL_BUSY, 32'd1, "busy_run");
    for (int i = 0; i < 32; i++) begin
      expectNow(SEL_PV, 32'd0, "pv_run");
      if (i == injAt) begin
        op = injOp;
        expectNow(SEL_MF, (injOp == F_MFHI) ? expHi : (injOp == F_MFLO) ? expLo : 32'd0, "mf_busy");
        @(posedge clk);
        #1;
        expectNow(SEL_HI, expHi, "hi_hold_run");
        expectNow(SEL_LO, expLo, "lo_hold_run");
      end else begin
        applyStimulus(opc, a, b);
      end
    end
    expectNow(SEL_PV, 32'd1, "pv_wait");
    applyStimulus(opc, a ^ 32'h5, b ^ 32'h3);
    expectNow(SEL_PV, 32'd1, "pv_hold_wait");
    expectNow(SEL_BUSY, 32'd1, "busy_wait");
    expectNow(SEL_HI, expHi, "hi_before_commit");
    applyStimulus(F_HILO_WR, 32'd0, 32'd0);
    expHi = exp[63:32];
    expLo = exp[31:0];
    expectNow(SEL_BUSY, 32'd0, "busy_done");
    expectNow(SEL_PV, 32'd0, "pv_done");
    applyStimulus(F_HILO_WR, 32'd0, 32'd0);
    expectNow(SEL_HI, expHi, "hi_idle_wr_ignored");
    expectNow(SEL_LO, expLo, "lo_idle_wr_ignored");
    applyStimulus(6'd0, 32'd0, 32'd0);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc        = 0;
    errors     = 0;
    checks     = 0;
    commitSeen = 1'b0;
    expHi      = '0;
    expLo      = '0;
    reset      = 1'b1;
    op         = '0;
    src_a      = '0;
    src_b      = '0;
    @(posedge clk);
    #1;
    applyStimulus(6'd0, 32'd0, 32'd0);
    reset = 1'b0;
    expectNow(SEL_BUSY, 32'd0, "reset_busy");
    expectNow(SEL_PV, 32'd0, "reset_pv");
    expectNow(SEL_HI, 32'd0, "reset_hi");
    expectNow(SEL_LO, 32'd0, "reset_lo");
    applyStimulus(F_HILO_WR, 32'd0, 32'd0);

    runMultiply(F_MULTU, 32'd3, 32'd5, 64'd15, -1, 6'd0);
    runMultiply(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1, 6'd0);
    runMultiply(F_MULTU, 32'd0, 32'hFFFFFFFF, 64'd0, -1, 6'd0);
    runMultiply(F_MULTU, 32'h80000000, 32'd2, 64'h00000001_00000000, -1, 6'd0);
    runMultiply(F_MULTU, 32'd12345, 32'd678, 64'h00000000_007FB6F6, 9, F_HILO_WR);
    runMultiply(F_MULTU, 32'd7, 32'd9, 64'd63, -1, 6'd0);
    runMultiply(F_MULTU, 32'd6, 32'd7, 64'd42, 5, F_MFLO);
    readMf(F_MFLO, 32'd42, "mflo_after");
    readMf(F_MFHI, 32'd0, "mfhi_after");
    readMf(6'd0, 32'd0, "mf_noop");

    // Reset mid-RUN abandons the product and clears HI/LO
    runMultiply(F_MULTU, 32'd7, 32'd9, 64'd63, -1, 6'd0);
    applyStimulus(F_MULTU, 32'd100, 32'd100);
    for (int i = 0; i < 14; i++) applyStimulus(F_MULTU, 32'd100, 32'd100);
    expectNow(SEL_BUSY, 32'd1, "busy_before_reset");
    reset = 1'b1;
    applyStimulus(F_MULTU, 32'd100, 32'd100);
    reset = 1'b0;
    expHi = '0;
    expLo = '0;
    expectNow(SEL_BUSY, 32'd0, "busy_after_reset");
    expectNow(SEL_PV, 32'd0, "pv_after_reset");
    expectNow(SEL_HI, 32'd0, "hi_after_reset");
    expectNow(SEL_LO, 32'd0, "lo_after_reset");
    applyStimulus(6'd0, 32'd0, 32'd0);
    runMultiply(F_MULTU, 32'd2, 32'd2, 64'd4, -1, 6'd0);

`ifdef MULTU_HILO_SIGNED_EN
    runMultiply(F_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, -1, 6'd0);
`else
    applyStimulus(F_MULT, 32'hFFFFFFFE, 32'd3);
    expectNow(SEL_BUSY, 32'd0, "mult_noop_busy");
    applyStimulus(6'd0, 32'd0, 32'd0);
    expectNow(SEL_BUSY, 32'd0, "mult_noop_busy2");
    expectNow(SEL_LO, 32'd4, "mult_noop_lo");
`endif

    applyStimulus(6'd0, 32'd0, 32'd0);
    applyStimulus(6'd0, 32'd0, 32'd0);
    checkOutput("prodq_drained", 64'(prodQ.size()), 64'd0);
    checkOutput("chkq_drained", 64'(chkQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
